// File: rtl/iob_eth_rx_pkg.sv
// Shared Ethernet receive constants, rx state encodings and the CRC-32 byte step.
package iob_eth_rx_pkg;

    localparam int ETH_MAC_ADDR_W = 48;
    localparam int ETH_DATA_W     = 8;
    localparam int ETH_BUF_ADDR_W = 11;

    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [31:0] ETH_CRC_RESIDUE = 32'hC704DD7B;
    localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
    localparam int          ETH_MIN_FRAME   = 18;

    localparam logic [2:0] RX_IDLE      = 3'd0;
    localparam logic [2:0] RX_PREAMBLE  = 3'd1;
    localparam logic [2:0] RX_DATA_L    = 3'd2;
    localparam logic [2:0] RX_DATA_H    = 3'd3;
    localparam logic [2:0] RX_END       = 3'd4;
    localparam logic [2:0] RX_DONE      = 3'd5;
    localparam logic [2:0] RX_DROP      = 3'd6;
    localparam logic [2:0] RX_WAIT_IDLE = 3'd7;

    // Reflected CRC-32: the wire sends each byte LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ ETH_CRC_POLY;
            else             c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/iob_eth_crc.sv
// CRC-32 engine; crc is presented MSB-first so the full-frame residue reads 0xC704DD7B.
module iob_eth_crc
    import iob_eth_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        data_valid,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (start)           crc_d = 32'hFFFFFFFF;
        else if (data_valid) crc_d = crc32_byte(crc_q, data);
    end

    always_ff @(posedge clk) begin
        if (rst) crc_q <= 32'hFFFFFFFF;
        else     crc_q <= crc_d;
    end

    always_comb begin
        crc = '0;
        for (int i = 0; i < 32; i++) crc[i] = crc_q[31-i];
    end

endmodule

// File: rtl/iob_eth_rx.sv
// MII receive path: preamble/SFD strip, nibble-to-byte assembly, MAC filter,
// buffer writes and FCS check, holding the received status until acknowledged.
module iob_eth_rx
    import iob_eth_rx_pkg::*;
#(
    parameter int BUF_ADDR_W = ETH_BUF_ADDR_W,
    parameter int DATA_W     = ETH_DATA_W,
    parameter int MAC_ADDR_W = ETH_MAC_ADDR_W
) (
    input  logic                  RX_CLK,
    input  logic                  rst,
    input  logic                  RX_DV,
    input  logic [3:0]            RX_DATA,
    input  logic [MAC_ADDR_W-1:0] mac_addr,
    output logic [BUF_ADDR_W-1:0] addr,
    output logic [DATA_W-1:0]     data,
    output logic                  wr,
    output logic                  received,
    output logic [BUF_ADDR_W:0]   nbytes,
    output logic                  crc_ok,
    input  logic                  rcv_ack
);

    localparam logic [BUF_ADDR_W:0] CNT_ONE      = (BUF_ADDR_W+1)'(1);
    localparam logic [BUF_ADDR_W:0] CNT_MAC_LAST = (BUF_ADDR_W+1)'(5);
    localparam logic [BUF_ADDR_W:0] CNT_MIN      = (BUF_ADDR_W+1)'(ETH_MIN_FRAME);

    logic [2:0]            state_q, state_d;
    logic [3:0]            pre_q, pre_d;
    logic [3:0]            low_q, low_d;
    logic [BUF_ADDR_W:0]   cnt_q, cnt_d;
    logic                  uc_q, uc_d;
    logic                  bc_q, bc_d;
    logic                  wr_q, wr_d;
    logic [BUF_ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  received_q, received_d;
    logic [BUF_ADDR_W:0]   nbytes_q, nbytes_d;
    logic                  crc_ok_q, crc_ok_d;

    logic [7:0]  rx_byte;
    logic [7:0]  mac_byte;
    logic        uc_next;
    logic        bc_next;
    logic        sfd_hit;
    logic        byte_stb;
    logic [31:0] crc;

    assign rx_byte  = {RX_DATA, low_q};
    assign mac_byte = 8'(mac_addr >> {cnt_q[2:0], 3'b000});
    assign uc_next  = uc_q & (rx_byte == mac_byte);
    assign bc_next  = bc_q & (rx_byte == 8'hFF);

    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        low_d      = low_q;
        cnt_d      = cnt_q;
        uc_d       = uc_q;
        bc_d       = bc_q;
        wr_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        received_d = received_q;
        nbytes_d   = nbytes_q;
        crc_ok_d   = crc_ok_q;
        sfd_hit    = 1'b0;
        byte_stb   = 1'b0;

        case (state_q)
            RX_IDLE: begin
                pre_d = RX_DATA;
                if (RX_DV) state_d = RX_PREAMBLE;
            end
            RX_PREAMBLE: begin
                pre_d = RX_DATA;
                if (!RX_DV) begin
                    state_d = RX_IDLE;
                end else if ({RX_DATA, pre_q} == ETH_SFD) begin
                    state_d = RX_DATA_L;
                    cnt_d   = '0;
                    uc_d    = 1'b1;
                    bc_d    = 1'b1;
                    sfd_hit = 1'b1;
                end
            end
            RX_DATA_L: begin
                if (RX_DV) begin
                    low_d   = RX_DATA;
                    state_d = RX_DATA_H;
                end else begin
                    state_d = RX_END;
                end
            end
            RX_DATA_H: begin
                // Odd nibble count or a byte past the buffer end aborts the frame.
                if (!RX_DV || cnt_q[BUF_ADDR_W]) begin
                    state_d = RX_DROP;
                end else begin
                    byte_stb = 1'b1;
                    wr_d     = 1'b1;
                    addr_d   = cnt_q[BUF_ADDR_W-1:0];
                    data_d   = DATA_W'(rx_byte);
                    cnt_d    = cnt_q + CNT_ONE;
                    state_d  = RX_DATA_L;
                    if (cnt_q <= CNT_MAC_LAST) begin
                        uc_d = uc_next;
                        bc_d = bc_next;
                        if (cnt_q == CNT_MAC_LAST && !uc_next && !bc_next) state_d = RX_DROP;
                    end
                end
            end
            RX_END: begin
                if (cnt_q < CNT_MIN) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d    = RX_DONE;
                    received_d = 1'b1;
                    nbytes_d   = cnt_q;
                    crc_ok_d   = (crc == ETH_CRC_RESIDUE);
                end
            end
            RX_DONE: begin
                if (rcv_ack) begin
                    received_d = 1'b0;
                    crc_ok_d   = 1'b0;
                    state_d    = RX_WAIT_IDLE;
                end
            end
            RX_DROP, RX_WAIT_IDLE: begin
                if (!RX_DV) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            state_q    <= RX_IDLE;
            pre_q      <= '0;
            low_q      <= '0;
            cnt_q      <= '0;
            uc_q       <= 1'b0;
            bc_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            received_q <= 1'b0;
            nbytes_q   <= '0;
            crc_ok_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            low_q      <= low_d;
            cnt_q      <= cnt_d;
            uc_q       <= uc_d;
            bc_q       <= bc_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            received_q <= received_d;
            nbytes_q   <= nbytes_d;
            crc_ok_q   <= crc_ok_d;
        end
    end

    iob_eth_crc u_crc (
        .clk        (RX_CLK),
        .rst        (rst),
        .start      (sfd_hit),
        .data_valid (byte_stb),
        .data       (rx_byte),
        .crc        (crc)
    );

    assign wr       = wr_q;
    assign addr     = addr_q;
    assign data     = data_q;
    assign received = received_q;
    assign nbytes   = nbytes_q;
    assign crc_ok   = crc_ok_q;

endmodule
